// File: rtl/cpu_prog_loader_if.sv
// Load-port bundle between the serial program loader and the CPU memory.
// master: the loader (takes rx/ena, drives the write port and status).
// slave:  the side that feeds the loader and consumes its write port.
interface cpu_prog_loader_if;
  logic       ena;
  logic       rx;
  logic       loading;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       done;
  logic       err;

  modport master (
    input  ena, rx,
    output loading, wr_en, wr_addr, wr_data, done, err
  );

  modport slave (
    output ena, rx,
    input  loading, wr_en, wr_addr, wr_data, done, err
  );
endinterface

// File: rtl/cpu_prog_loader.sv
// Serial program loader for the UltraTiny CPU 16-byte memory.
// Receives 8N1 UART bytes, parses a frame (0xA5, count N, N data bytes
// and, when PROG_LOADER_CSUM_EN is defined, a trailing XOR checksum) and
// drives the CPU load-mode write port. Without PROG_LOADER_CSUM_EN the
// frame ends with its last data byte and no checksum byte is expected.
module cpu_prog_loader #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_prog_loader_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  typedef enum logic [1:0] {
    P_SYNC,
    P_COUNT,
`ifdef PROG_LOADER_CSUM_EN
    P_DATA,
    P_CSUM
`else
    P_DATA
`endif
  } parse_state_t;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t        rx_state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             stop_tick, byte_valid, frame_err;

  parse_state_t     p_state_q;
  logic [4:0]       remain_q;
  logic [3:0]       addr_cnt_q;
  logic             loading_q, wr_en_q, done_q, err_q;
  logic [3:0]       wr_addr_q;
  logic [7:0]       wr_data_q;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]       csum_q;
`endif

  // Two-flop synchronizer for rx plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // UART receiver: find the start edge, sample mid-bit, shift data in LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= R_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else if (!bus.ena) begin
      rx_state_q <= R_IDLE;
      cnt_q      <= '0;
    end else begin
      case (rx_state_q)
        R_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= R_START;
            cnt_q      <= '0;
          end
        end
        R_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            // A high mid-start sample is a glitch, not a byte.
            rx_state_q <= rx_sync_q ? R_IDLE : R_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q     <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) rx_state_q <= R_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_STOP: begin
          // Returning to idle at mid-stop leaves time to catch a back-to-back start edge.
          if (cnt_q == FULL_M1) begin
            cnt_q      <= '0;
            rx_state_q <= R_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= R_IDLE;
      endcase
    end
  end

  // Stop-bit mid-sample: a good stop bit delivers the byte, a low one is a framing error.
  always_comb begin
    stop_tick  = bus.ena && (rx_state_q == R_STOP) && (cnt_q == FULL_M1);
    byte_valid = stop_tick && rx_sync_q;
    frame_err  = stop_tick && !rx_sync_q;
  end

  // Frame parser with registered write port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state_q  <= P_SYNC;
      remain_q   <= '0;
      addr_cnt_q <= '0;
      loading_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (!bus.ena) begin
        // err is deliberately kept so a host can still read why a load stopped.
        p_state_q <= P_SYNC;
        loading_q <= 1'b0;
      end else if (frame_err) begin
        err_q     <= 1'b1;
        loading_q <= 1'b0;
        p_state_q <= P_SYNC;
      end else if (byte_valid) begin
        case (p_state_q)
          P_SYNC: begin
            if (shift_q == SYNC_BYTE) begin
              p_state_q <= P_COUNT;
              loading_q <= 1'b1;
              err_q     <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
              csum_q    <= '0;
`endif
            end
          end
          P_COUNT: begin
            if ((shift_q != 8'd0) && (shift_q <= 8'd16)) begin
              remain_q   <= shift_q[4:0];
              addr_cnt_q <= '0;
              p_state_q  <= P_DATA;
            end else begin
              err_q     <= 1'b1;
              loading_q <= 1'b0;
              p_state_q <= P_SYNC;
            end
          end
          P_DATA: begin
            wr_en_q    <= 1'b1;
            wr_addr_q  <= addr_cnt_q;
            wr_data_q  <= shift_q;
            addr_cnt_q <= addr_cnt_q + 1'b1;
            remain_q   <= remain_q - 1'b1;
`ifdef PROG_LOADER_CSUM_EN
            csum_q     <= csum_q ^ shift_q;
            if (remain_q == 5'd1) p_state_q <= P_CSUM;
`else
            if (remain_q == 5'd1) begin
              done_q    <= 1'b1;
              loading_q <= 1'b0;
              p_state_q <= P_SYNC;
            end
`endif
          end
`ifdef PROG_LOADER_CSUM_EN
          P_CSUM: begin
            if (shift_q == csum_q) done_q <= 1'b1;
            else                   err_q  <= 1'b1;
            loading_q <= 1'b0;
            p_state_q <= P_SYNC;
          end
`endif
          default: p_state_q <= P_SYNC;
        endcase
      end
    end
  end

  assign bus.loading = loading_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Testbench for cpu_prog_loader: UART byte driver, frame-level reference
// model feeding an event scoreboard, and a monitor that checks every write
// strobe, done pulse and err transition against it.
module tb_cpu_prog_loader;
  localparam int CPB     = 4;
  localparam int EV_WR   = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;
  localparam int EV_CLR  = 3;

  typedef struct {
    int         k;
    logic [3:0] a;
    logic [7:0] d;
    logic       ld;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  ev_t  exp_q[$];
  logic [7:0] frame_buf [16];

  cpu_prog_loader_if bus ();

  cpu_prog_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- reference model (frame rules) ----------------
  int         m_phase;   // 0 wait sync, 1 count, 2 data, 3 checksum
  int         m_left;
  int         m_addr;
  logic [7:0] m_x;
  logic       m_err;
  logic [3:0] m_la;
  logic [7:0] m_ld;

  function automatic void push(input int k, input logic [3:0] a, input logic [7:0] d, input logic ld);
    ev_t e;
    e.k = k; e.a = a; e.d = d; e.ld = ld;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_left = 0; m_addr = 0; m_x = 8'h00;
    m_err = 1'b0; m_la = 4'h0; m_ld = 8'h00;
  endfunction

  function automatic void set_err();
    if (!m_err) push(EV_ERR, 4'h0, 8'h00, 1'b0);
    m_err = 1'b1;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    bit last;
    if (!stop_ok) begin
      set_err();
      m_phase = 0;
      return;
    end
    case (m_phase)
      0: if (b == 8'hA5) begin
           if (m_err) push(EV_CLR, 4'h0, 8'h00, 1'b1);
           m_err = 1'b0;
           m_phase = 1;
         end
      1: if (b >= 8'd1 && b <= 8'd16) begin
           m_left = int'(b); m_addr = 0; m_x = 8'h00; m_phase = 2;
         end else begin
           set_err();
           m_phase = 0;
         end
      2: begin
           m_x = m_x ^ b;
           m_left--;
           last = (m_left == 0);
`ifdef PROG_LOADER_CSUM_EN
           push(EV_WR, 4'(m_addr), b, 1'b1);
`else
           push(EV_WR, 4'(m_addr), b, !last);
`endif
           m_la = 4'(m_addr);
           m_ld = b;
           m_addr++;
           if (last) begin
`ifdef PROG_LOADER_CSUM_EN
             m_phase = 3;
`else
             push(EV_DONE, 4'h0, 8'h00, 1'b0);
             m_phase = 0;
`endif
           end
         end
      default: begin
           if (b == m_x) push(EV_DONE, 4'h0, 8'h00, 1'b0);
           else set_err();
           m_phase = 0;
         end
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic err_prev = 1'b0;

  task automatic expect_ev(input int k, input logic [3:0] a, input logic [7:0] d, input logic ld);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got kind %0d addr %0h data %0h loading %0b, required none", k, a, d, ld);
    end else begin
      e = exp_q.pop_front();
      check("event(kind,ld,addr,data)", {8'(k), 7'd0, ld, 4'd0, a, d}, {8'(e.k), 7'd0, e.ld, 4'd0, e.a, e.d});
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      err_prev = 1'b0;
    end else begin
      if (bus.wr_en)             expect_ev(EV_WR, bus.wr_addr, bus.wr_data, bus.loading);
      if (bus.done)              expect_ev(EV_DONE, 4'h0, 8'h00, bus.loading);
      if (bus.err && !err_prev)  expect_ev(EV_ERR, 4'h0, 8'h00, bus.loading);
      if (!bus.err && err_prev)  expect_ev(EV_CLR, 4'h0, 8'h00, bus.loading);
      err_prev = bus.err;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v);
    bus.rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(b[i]);
    drive(stop_ok ? 1'b1 : 1'b0);
    if (!stop_ok) begin
      drive(1'b1);
      drive(1'b1);
    end
  endtask

  task automatic maybe_gap(input bit gaps);
    if (gaps && $urandom_range(0, 1) == 1) begin
      repeat ($urandom_range(1, 2)) drive(1'b1);
    end
  endtask

  task automatic send_frame(input int n, input bit bad, input bit gaps);
    logic [7:0] x;
    x = 8'h00;
    send_byte(8'hA5, 1'b1);
    maybe_gap(gaps);
    send_byte(8'(n), 1'b1);
    for (int i = 0; i < n; i++) begin
      maybe_gap(gaps);
      send_byte(frame_buf[i], 1'b1);
      x = x ^ frame_buf[i];
    end
`ifdef PROG_LOADER_CSUM_EN
    maybe_gap(gaps);
    send_byte(bad ? ~x : x, 1'b1);
`else
    if (bad) drive(1'b1);
`endif
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check({name, "_drain"}, exp_q.size(), 0);
    check({name, "_hold_addr"}, {28'd0, bus.wr_addr}, {28'd0, m_la});
    check({name, "_hold_data"}, {24'd0, bus.wr_data}, {24'd0, m_ld});
    check({name, "_err"}, {31'd0, bus.err}, {31'd0, m_err});
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_loading"}, {31'd0, bus.loading}, 32'd0);
    check({name, "_wr_en"},   {31'd0, bus.wr_en},   32'd0);
    check({name, "_wr_addr"}, {28'd0, bus.wr_addr}, 32'd0);
    check({name, "_wr_data"}, {24'd0, bus.wr_data}, 32'd0);
    check({name, "_done"},    {31'd0, bus.done},    32'd0);
    check({name, "_err"},     {31'd0, bus.err},     32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int sel;
    int n;
    model_reset();
    bus.rx  = 1'b1;
    bus.ena = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Good frame, back-to-back bytes.
    frame_buf[0] = 8'h10; frame_buf[1] = 8'h2A; frame_buf[2] = 8'hFF;
    send_frame(3, 1'b0, 1'b0);
    drain("good3");

    // Bad checksum, then a good frame clears err.
    frame_buf[0] = 8'h01; frame_buf[1] = 8'h02;
    send_frame(2, 1'b1, 1'b0);
    drain("badcsum");
    frame_buf[0] = 8'hA5; frame_buf[1] = 8'h5A;
    send_frame(2, 1'b0, 1'b0);
    drain("a5_as_data");

    // Illegal counts, each followed by recovery.
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1);
    drain("count0");
    send_byte(8'hA5, 1'b1); send_byte(8'h11, 1'b1);
    drain("count17");
    frame_buf[0] = 8'h77;
    send_frame(1, 1'b0, 1'b0);
    drain("recover");

    // Framing error and a short glitch.
    send_byte(8'h3C, 1'b0);
    drain("framing");
    bus.rx = 1'b0;
    @(posedge clk); #1;
    bus.rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    drain("glitch");

    // err retained while disabled.
    bus.ena = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("ena_err_hold", {31'd0, bus.err}, {31'd0, m_err});
    check("ena_loading", {31'd0, bus.loading}, 32'd0);
    bus.ena = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Full 16-byte frame 00..0F.
    for (int i = 0; i < 16; i++) frame_buf[i] = 8'(i);
    send_frame(16, 1'b0, 1'b0);
    drain("full16");

    // Reset during the 2nd data byte.
    send_byte(8'hA5, 1'b1); send_byte(8'h04, 1'b1); send_byte(8'h3E, 1'b1);
    drain("pre_rst");
    drive(1'b0); drive(1'b1); drive(1'b0);
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) frame_buf[i] = 8'($urandom);
    send_frame(16, 1'b0, 1'b0);
    drain("after_rst");

    // ena dropped during the 2nd data byte.
    send_byte(8'hA5, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'hC3, 1'b1);
    drain("pre_ena");
    drive(1'b0); drive(1'b0); drive(1'b1);
    bus.ena = 1'b0;
    bus.rx  = 1'b1;
    m_phase = 0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_loading", {31'd0, bus.loading}, 32'd0);
    check("abort_wr_en",   {31'd0, bus.wr_en},   32'd0);
    check("abort_done",    {31'd0, bus.done},    32'd0);
    check("abort_err",     {31'd0, bus.err},     {31'd0, m_err});
    bus.ena = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) frame_buf[i] = 8'($urandom);
    send_frame(16, 1'b0, 1'b0);
    drain("after_ena");

    // Randomized frames with random gaps and error injection.
    for (int f = 0; f < 30; f++) begin
      sel = $urandom_range(0, 9);
      n   = $urandom_range(1, 16);
      for (int i = 0; i < 16; i++) frame_buf[i] = 8'($urandom);
      case (sel)
        0: begin
             send_byte(8'hA5, 1'b1);
             maybe_gap(1'b1);
             send_byte(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(17, 255)), 1'b1);
           end
        1: begin
             send_byte(8'hA5, 1'b1);
             send_byte(8'(n), 1'b1);
             for (int i = 0; i < n / 2; i++) send_byte(frame_buf[i], 1'b1);
             send_byte(8'($urandom), 1'b0);
           end
        2: send_frame(n, 1'b1, 1'b1);
        3: begin
             send_byte(8'($urandom), 1'b1);
             send_frame(n, 1'b0, 1'b1);
           end
        default: send_frame(n, 1'b0, 1'b1);
      endcase
      maybe_gap(1'b1);
      drain("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
